// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states, access-size decode.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef logic [1:0] lsu_state_t;
   localparam lsu_state_t IDLE = 2'd0;
   localparam lsu_state_t BEAT = 2'd1;
   localparam lsu_state_t RESP = 2'd2;

   // Access size in bytes; 0 marks an undefined funct3.
   function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
      case (funct3)
         F3_B, F3_BU: size_bytes = 3'd1;
         F3_H, F3_HU: size_bytes = 3'd2;
         F3_W:        size_bytes = 3'd4;
         default:     size_bytes = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response and data-memory bus of the load/store unit.
// slave = the LSU itself, master = the pipeline/memory environment around it.
interface lsu_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  req_valid_i;
   logic                  req_ready_o;
   logic                  req_we_i;
   logic [2:0]            req_funct3_i;
   logic [DATA_WIDTH-1:0] req_addr_i;
   logic [DATA_WIDTH-1:0] req_wdata_i;
   logic                  resp_valid_o;
   logic [DATA_WIDTH-1:0] resp_rdata_o;
   logic                  resp_err_o;
   logic                  mem_we_o;
   logic                  mem_byte_op_o;
   logic [DATA_WIDTH-1:0] mem_addr_o;
   logic [DATA_WIDTH-1:0] mem_wd_o;
   logic [DATA_WIDTH-1:0] mem_rd_i;

   modport slave (
      input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, mem_rd_i,
      output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
      output mem_we_o, mem_byte_op_o, mem_addr_o, mem_wd_o
   );

   modport master (
      output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, mem_rd_i,
      input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
      input  mem_we_o, mem_byte_op_o, mem_addr_o, mem_wd_o
   );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane handling: merges load beats into byte lanes, extends the result,
// and selects the store byte for a given beat.
module lsu_align import lsu_pkg::*; #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BYTE_WIDTH = 8,
   parameter int unsigned IDX_W      = 2
) (
   input  logic [2:0]            funct3_i,
   input  logic                  word_mode_i,
   input  logic [IDX_W-1:0]      beat_idx_i,
   input  logic [DATA_WIDTH-1:0] lanes_i,
   input  logic [DATA_WIDTH-1:0] mem_rd_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [IDX_W-1:0]      st_idx_i,
   output logic [DATA_WIDTH-1:0] lanes_o,
   output logic [DATA_WIDTH-1:0] ext_data_o,
   output logic [BYTE_WIDTH-1:0] st_byte_o
);
   localparam int unsigned NUM_LANES = DATA_WIDTH / BYTE_WIDTH;
   localparam int unsigned HALF      = 2 * BYTE_WIDTH;

   logic [DATA_WIDTH-1:0] merged;

   always_comb begin
      merged = lanes_i;
      if (word_mode_i) begin
         merged = mem_rd_i;
      end else begin
         for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (beat_idx_i == IDX_W'(i)) merged[i*BYTE_WIDTH +: BYTE_WIDTH] = mem_rd_i[BYTE_WIDTH-1:0];
         end
      end
   end

   always_comb begin
      case (funct3_i)
         F3_B:    ext_data_o = {{(DATA_WIDTH-BYTE_WIDTH){merged[BYTE_WIDTH-1]}},
                                merged[BYTE_WIDTH-1:0]};
         F3_BU:   ext_data_o = {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, merged[BYTE_WIDTH-1:0]};
         F3_H:    ext_data_o = {{(DATA_WIDTH-HALF){merged[HALF-1]}}, merged[HALF-1:0]};
         F3_HU:   ext_data_o = {{(DATA_WIDTH-HALF){1'b0}}, merged[HALF-1:0]};
         default: ext_data_o = merged;
      endcase
   end

   always_comb begin
      st_byte_o = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         if (st_idx_i == IDX_W'(i)) st_byte_o = wdata_i[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
   end

   assign lanes_o = merged;

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: sequences CPU data accesses into byte or aligned-word memory beats.
// Define MISALIGN_TRAP_EN to fault misaligned H/W accesses instead of splitting them.
module load_store_unit import lsu_pkg::*; #(
   parameter int unsigned           DATA_WIDTH    = 32,
   parameter int unsigned           BYTE_WIDTH    = 8,
   parameter logic [DATA_WIDTH-1:0] START_ADDRESS = 32'h0001_0000,
   parameter logic [DATA_WIDTH-1:0] END_ADDRESS   = 32'h0001_FFFF
) (
   input logic  clk_i,
   input logic  rst_i,
   lsu_if.slave bus
);
   localparam int unsigned NUM_LANES = DATA_WIDTH / BYTE_WIDTH;
   localparam int unsigned IDX_W     = $clog2(NUM_LANES);

   lsu_state_t            state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d, last_q, last_d;
   logic                  we_q, we_d, word_q, word_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d, lanes_q, lanes_d;
   logic                  mem_we_q, mem_we_d, mem_byte_q, mem_byte_d;
   logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d, mem_wd_q, mem_wd_d;
   logic                  resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
   logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

   logic                  ready, accept, legal, in_range, word_beat, fault;
   logic [2:0]            size;
   logic [DATA_WIDTH:0]   last_addr;
   logic [DATA_WIDTH-1:0] lanes_merged, load_data;
   logic [BYTE_WIDTH-1:0] st_byte;

   assign ready  = (state_q != BEAT);
   assign accept = bus.req_valid_i && ready;

   // One extra address bit so a wrap past the top of memory reads as out of range.
   always_comb begin
      size      = size_bytes(bus.req_funct3_i);
      last_addr = {1'b0, bus.req_addr_i} + (DATA_WIDTH+1)'(size) - (DATA_WIDTH+1)'(1);
      in_range  = (bus.req_addr_i >= START_ADDRESS) && (last_addr <= {1'b0, END_ADDRESS});
      legal     = (size != 3'd0) && !(bus.req_we_i && bus.req_funct3_i[2]);
      word_beat = (bus.req_funct3_i == F3_W) && (bus.req_addr_i[1:0] == 2'b00);
`ifdef MISALIGN_TRAP_EN
      fault = !legal || !in_range
              || (((bus.req_funct3_i == F3_H) || (bus.req_funct3_i == F3_HU)) && bus.req_addr_i[0])
              || ((bus.req_funct3_i == F3_W) && (bus.req_addr_i[1:0] != 2'b00));
`else
      fault = !legal || !in_range;
`endif
   end

   lsu_align #(
      .DATA_WIDTH (DATA_WIDTH),
      .BYTE_WIDTH (BYTE_WIDTH),
      .IDX_W      (IDX_W)
   ) u_align (
      .funct3_i    (funct3_q),
      .word_mode_i (word_q),
      .beat_idx_i  (idx_q),
      .lanes_i     (lanes_q),
      .mem_rd_i    (bus.mem_rd_i),
      .wdata_i     (wdata_q),
      .st_idx_i    (idx_q + IDX_W'(1)),
      .lanes_o     (lanes_merged),
      .ext_data_o  (load_data),
      .st_byte_o   (st_byte)
   );

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      last_d       = last_q;
      we_d         = we_q;
      word_d       = word_q;
      funct3_d     = funct3_q;
      wdata_d      = wdata_q;
      lanes_d      = lanes_q;
      mem_we_d     = mem_we_q;
      mem_byte_d   = mem_byte_q;
      mem_addr_d   = mem_addr_q;
      mem_wd_d     = mem_wd_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = '0;
      resp_err_d   = 1'b0;
      case (state_q)
         BEAT: begin
            lanes_d = lanes_merged;
            if (idx_q == last_q) begin
               state_d      = RESP;
               mem_we_d     = 1'b0;
               resp_valid_d = 1'b1;
               resp_rdata_d = we_q ? '0 : load_data;
            end else begin
               idx_d      = idx_q + IDX_W'(1);
               mem_addr_d = mem_addr_q + DATA_WIDTH'(1);
               mem_wd_d   = {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, st_byte};
            end
         end
         default: begin
            // IDLE and RESP both accept, which gives back-to-back operation.
            state_d = IDLE;
            if (accept) begin
               if (fault) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else begin
                  state_d    = BEAT;
                  idx_d      = '0;
                  last_d     = word_beat ? '0 : IDX_W'(size - 3'd1);
                  we_d       = bus.req_we_i;
                  word_d     = word_beat;
                  funct3_d   = bus.req_funct3_i;
                  wdata_d    = bus.req_wdata_i;
                  lanes_d    = '0;
                  mem_we_d   = bus.req_we_i;
                  mem_byte_d = !word_beat;
                  mem_addr_d = bus.req_addr_i;
                  mem_wd_d   = word_beat ? bus.req_wdata_i
                               : {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, bus.req_wdata_i[BYTE_WIDTH-1:0]};
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         last_q       <= '0;
         we_q         <= 1'b0;
         word_q       <= 1'b0;
         funct3_q     <= '0;
         wdata_q      <= '0;
         lanes_q      <= '0;
         mem_we_q     <= 1'b0;
         mem_byte_q   <= 1'b0;
         mem_addr_q   <= '0;
         mem_wd_q     <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         last_q       <= last_d;
         we_q         <= we_d;
         word_q       <= word_d;
         funct3_q     <= funct3_d;
         wdata_q      <= wdata_d;
         lanes_q      <= lanes_d;
         mem_we_q     <= mem_we_d;
         mem_byte_q   <= mem_byte_d;
         mem_addr_q   <= mem_addr_d;
         mem_wd_q     <= mem_wd_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign bus.req_ready_o   = ready;
   assign bus.resp_valid_o  = resp_valid_q;
   assign bus.resp_rdata_o  = resp_rdata_q;
   assign bus.resp_err_o    = resp_err_q;
   assign bus.mem_we_o      = mem_we_q;
   assign bus.mem_byte_op_o = mem_byte_q;
   assign bus.mem_addr_o    = mem_addr_q;
   assign bus.mem_wd_o      = mem_wd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, hand sequences for
// multi-cycle corners, and random traffic against a byte-array reference model.
module tb_load_store_unit;
   localparam logic [31:0] START = 32'h0001_0000;
   localparam logic [31:0] ENDA  = 32'h0001_FFFF;
`ifdef MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif
   localparam logic [2:0] FB = 3'b000, FH = 3'b001, FW = 3'b010, FBU = 3'b100, FHU = 3'b101;
   localparam int NV = 20;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic mem_clear;
   always #5 clk = ~clk;

   lsu_if bus ();

   load_store_unit dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   // Data memory: byte array covering the legal window, little-endian word beats.
   logic [7:0]  dmem [65536];
   logic [15:0] ma;
   assign ma = bus.mem_addr_o[15:0];
   assign bus.mem_rd_i = bus.mem_byte_op_o ? {24'h0, dmem[ma]}
                         : {dmem[ma + 16'd3], dmem[ma + 16'd2], dmem[ma + 16'd1], dmem[ma]};

   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 65536; i++) dmem[i] <= 8'h00;
      end else if (bus.mem_we_o) begin
         if (bus.mem_byte_op_o) begin
            dmem[ma] <= bus.mem_wd_o[7:0];
         end else begin
            dmem[ma]         <= bus.mem_wd_o[7:0];
            dmem[ma + 16'd1] <= bus.mem_wd_o[15:8];
            dmem[ma + 16'd2] <= bus.mem_wd_o[23:16];
            dmem[ma + 16'd3] <= bus.mem_wd_o[31:24];
         end
      end
   end

   logic [7:0]  ref_mem [65536];
   logic [31:0] tr_addr [4];
   logic [31:0] tr_wd   [4];
   logic        tr_we   [4];
   logic        tr_bop  [4];
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   // Issue one request; return response, latency in cycles after accept (0 = timeout), beats.
   task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                         output int lat, output int nb);
      bit done = 0;
      @(negedge clk);
      bus.req_valid_i  = 1'b1;
      bus.req_we_i     = we;
      bus.req_funct3_i = f3;
      bus.req_addr_i   = addr;
      bus.req_wdata_i  = wdata;
      @(posedge clk);
      #1 bus.req_valid_i = 1'b0;
      lat = 0; nb = 0; rdata = '0; err = 1'b0;
      for (int c = 1; c <= 12 && !done; c++) begin
         @(negedge clk);
         if (!bus.req_ready_o) begin
            if (nb < 4) begin
               tr_addr[nb] = bus.mem_addr_o;
               tr_wd[nb]   = bus.mem_wd_o;
               tr_we[nb]   = bus.mem_we_o;
               tr_bop[nb]  = bus.mem_byte_op_o;
            end
            nb++;
         end
         if (bus.resp_valid_o) begin
            lat = c; rdata = bus.resp_rdata_o; err = bus.resp_err_o; done = 1;
         end
      end
   endtask

   // Reference: access as a list of bytes; fault and beat count from the access rules.
   task automatic ref_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                         output int lat);
      int size, k;
      longint last;
      bit illegal, mis, oor;
      logic [31:0] v = 0;
      case (f3)
         FB, FBU: size = 1;
         FH, FHU: size = 2;
         FW:      size = 4;
         default: size = 0;
      endcase
      illegal = (size == 0) || (we && f3[2]);
      mis     = (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00);
      last    = longint'(addr) + longint'(size) - 1;
      oor     = (addr < START) || (last > longint'(ENDA));
      rdata   = 0;
      if (illegal || oor || (TRAP && mis)) begin
         err = 1'b1; lat = 1;
      end else begin
         err = 1'b0;
         k   = (size == 4 && !mis) ? 1 : size;
         lat = k + 1;
         for (int i = 0; i < size; i++) begin
            if (we) ref_mem[int'(addr - START) + i] = wdata[8*i +: 8];
            else v[8*i +: 8] = ref_mem[int'(addr - START) + i];
         end
         if (!we) begin
            case (f3)
               FB:      rdata = {{24{v[7]}}, v[7:0]};
               FH:      rdata = {{16{v[15]}}, v[15:0]};
               default: rdata = v;
            endcase
         end
      end
   endtask

   vec_t vt [NV];

   initial begin
      logic [31:0] rd, e_rd, a, d;
      logic        er, e_er, w;
      logic [2:0]  f;
      int          lat, e_lat, nb, nbr;
      logic [4:0]  rvv;
      logic [3:0]  rdy;
      bit          seen;

      vt[0]  = '{1'b1, FW,     32'h0001_0000, 32'hDEAD_BEEF, 32'h0, 1'b0, 2};
      vt[1]  = '{1'b0, FW,     32'h0001_0000, 32'h0, 32'hDEAD_BEEF, 1'b0, 2};
      vt[2]  = '{1'b1, FB,     32'h0001_0003, 32'h0000_0080, 32'h0, 1'b0, 2};
      vt[3]  = '{1'b0, FB,     32'h0001_0003, 32'h0, 32'hFFFF_FF80, 1'b0, 2};
      vt[4]  = '{1'b0, FBU,    32'h0001_0003, 32'h0, 32'h0000_0080, 1'b0, 2};
      vt[5]  = '{1'b1, FH,     32'h0001_0001, 32'h0000_1234, 32'h0, TRAP, TRAP ? 1 : 3};
      vt[6]  = '{1'b0, FH,     32'h0001_0001, 32'h0, TRAP ? 32'h0 : 32'h0000_1234, TRAP,
                 TRAP ? 1 : 3};
      vt[7]  = '{1'b0, FW,     32'h0001_0002, 32'h0, TRAP ? 32'h0 : 32'h0000_8012, TRAP,
                 TRAP ? 1 : 5};
      vt[8]  = '{1'b0, FH,     32'h0001_0002, 32'h0, TRAP ? 32'hFFFF_80AD : 32'hFFFF_8012,
                 1'b0, 3};
      vt[9]  = '{1'b0, FHU,    32'h0001_0002, 32'h0, TRAP ? 32'h0000_80AD : 32'h0000_8012,
                 1'b0, 3};
      vt[10] = '{1'b0, FW,     32'h0001_FFFE, 32'h0, 32'h0, 1'b1, 1};
      vt[11] = '{1'b1, FB,     32'h0000_FFFF, 32'h55, 32'h0, 1'b1, 1};
      vt[12] = '{1'b0, 3'b011, 32'h0001_0000, 32'h0, 32'h0, 1'b1, 1};
      vt[13] = '{1'b1, FBU,    32'h0001_0000, 32'h77, 32'h0, 1'b1, 1};
      vt[14] = '{1'b0, FW,     32'h0001_FFFC, 32'h0, 32'h0, 1'b0, 2};
      vt[15] = '{1'b0, FB,     32'h0001_FFFF, 32'h0, 32'h0, 1'b0, 2};
      vt[16] = '{1'b1, FW,     32'hFFFF_FFFE, 32'h1, 32'h0, 1'b1, 1};
      vt[17] = '{1'b0, 3'b110, 32'h0001_0000, 32'h0, 32'h0, 1'b1, 1};
      vt[18] = '{1'b0, FB,     32'h0001_0000, 32'h0, 32'hFFFF_FFEF, 1'b0, 2};
      vt[19] = '{1'b0, FW,     32'h0001_0000, 32'h0, TRAP ? 32'h80AD_BEEF : 32'h8012_34EF,
                 1'b0, 2};

      for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
      rst = 1'b1; mem_clear = 1'b1;
      bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_funct3_i = 3'b000;
      bus.req_addr_i = '0; bus.req_wdata_i = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      mem_clear = 1'b0;
      chk("rst_ready", 32'(bus.req_ready_o), 32'd1);
      chk("rst_resp_valid", 32'(bus.resp_valid_o), 32'd0);
      chk("rst_mem_we", 32'(bus.mem_we_o), 32'd0);
      chk("rst_byte_op", 32'(bus.mem_byte_op_o), 32'd0);
      chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
      chk("rst_mem_wd", bus.mem_wd_o, 32'h0);
      chk("rst_rdata", bus.resp_rdata_o, 32'h0);
      chk("rst_err", 32'(bus.resp_err_o), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         run_op(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, rd, er, lat, nb);
         chk($sformatf("vec%0d_rdata", i), rd, vt[i].rdata);
         chk($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].err));
         chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vt[i].lat));
      end

      // Aligned word store presents one word beat.
      run_op(1'b1, FW, 32'h0001_0084, 32'h1122_3344, rd, er, lat, nb);
      chk("sw_beats", 32'(nb), 32'd1);
      chk("sw_beat_addr", tr_addr[0], 32'h0001_0084);
      chk("sw_beat_wd", tr_wd[0], 32'h1122_3344);
      chk("sw_beat_we_bop", {30'h0, tr_we[0], tr_bop[0]}, 32'h2);

      // Halfword store split into ascending byte beats; mem_* hold afterwards.
      a = TRAP ? 32'h0001_0080 : 32'h0001_0081;
      run_op(1'b1, FH, a, 32'h0000_5678, rd, er, lat, nb);
      chk("sh_lat", 32'(lat), 32'd3);
      chk("sh_beats", 32'(nb), 32'd2);
      chk("sh_b0_addr", tr_addr[0], a);
      chk("sh_b0_wd", tr_wd[0], 32'h78);
      chk("sh_b1_addr", tr_addr[1], a + 32'd1);
      chk("sh_b1_wd", tr_wd[1], 32'h56);
      chk("sh_we_bop", {28'h0, tr_we[0], tr_we[1], tr_bop[0], tr_bop[1]}, 32'hF);
      @(negedge clk);
      chk("hold_mem_we", 32'(bus.mem_we_o), 32'd0);
      chk("hold_mem_addr", bus.mem_addr_o, a + 32'd1);
      chk("hold_mem_wd", bus.mem_wd_o, 32'h56);
      chk("sh_mem", {16'h0, dmem[a[15:0] + 16'd1], dmem[a[15:0]]}, 32'h5678);

      // Back-to-back: second request accepted during RESP of the first.
      @(negedge clk);
      bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_funct3_i = FB;
      bus.req_addr_i = 32'h0001_0090; bus.req_wdata_i = 32'h5A;
      @(posedge clk);
      #1 bus.req_addr_i = 32'h0001_0091; bus.req_wdata_i = 32'hA5;
      rvv = '0; rdy = '0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         rvv[c-1] = bus.resp_valid_o;
         if (c <= 4) rdy[c-1] = bus.req_ready_o;
         if (c == 2) begin
            @(posedge clk);
            #1 bus.req_valid_i = 1'b0;
         end
      end
      chk("b2b_resp_pulses", 32'(rvv), 32'h0A);
      chk("b2b_ready", 32'(rdy), 32'hA);
      chk("b2b_mem", {16'h0, dmem[16'h0091], dmem[16'h0090]}, 32'hA55A);

      // Reset in the middle of a split store drops the remaining beats.
`ifdef MISALIGN_TRAP_EN
      f = FH; a = 32'h0001_0040; d = 32'h0000_A1B2; nbr = 1;
`else
      f = FW; a = 32'h0001_0041; d = 32'hA1B2_C3D4; nbr = 2;
`endif
      @(negedge clk);
      bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_funct3_i = f;
      bus.req_addr_i = a; bus.req_wdata_i = d;
      @(posedge clk);
      #1 bus.req_valid_i = 1'b0;
      repeat (nbr) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rst_mid_mem_we", 32'(bus.mem_we_o), 32'd0);
      chk("rst_mid_ready", 32'(bus.req_ready_o), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.resp_valid_o) seen = 1;
      end
      chk("rst_mid_no_resp", 32'(seen), 32'd0);
      chk("rst_mid_ready_after", 32'(bus.req_ready_o), 32'd1);
      chk("rst_mid_mem", {dmem[16'h0044], dmem[16'h0043], dmem[16'h0042], dmem[16'h0041]},
          TRAP ? {8'h00, 8'h00, 8'h00, 8'h00} : {8'h00, 8'h00, 8'hC3, 8'hD4});
      chk("rst_mid_mem0", 32'(dmem[16'h0040]), TRAP ? 32'hB2 : 32'h00);

      // Random traffic in regions untouched by the directed part.
      for (int n = 0; n < 150; n++) begin
         case ($urandom_range(0, 9))
            7:       a = 32'h0001_FFF0 + 32'($urandom_range(0, 15));
            8:       a = 32'h0000_FFF8 + 32'($urandom_range(0, 7));
            9:       a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
            default: a = 32'h0001_0100 + 32'($urandom_range(0, 63));
         endcase
         f = 3'($urandom_range(0, 7));
         w = 1'($urandom_range(0, 1));
         d = $urandom;
         ref_op(w, f, a, d, e_rd, e_er, e_lat);
         run_op(w, f, a, d, rd, er, lat, nb);
         chk($sformatf("rnd%0d_rdata a=%h f3=%0d we=%0d", n, a, f, w), rd, e_rd);
         chk($sformatf("rnd%0d_err a=%h f3=%0d we=%0d", n, a, f, w), 32'(er), 32'(e_er));
         chk($sformatf("rnd%0d_lat a=%h f3=%0d we=%0d", n, a, f, w), 32'(lat), 32'(e_lat));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
